// File: rtl/uart_bus_responder.sv
// rtl/uart_bus_responder.sv - CPU bus register window bridging to a UART byte handshake
module uart_bus_responder #(
    parameter logic [15:0] BASE_ADDR = 16'hC000,
    parameter int          RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        cpuAccess,
    input  logic        readNotWrite,
    input  logic [7:0]  dataBusIn,
    output logic [7:0]  dataBusOut,
    output logic        interruptRequest,
    output logic [7:0]  txdata,
    output logic        txclk,
    input  logic        txready,
    input  logic [7:0]  rxdata,
    output logic        rxclk,
    input  logic        rxready
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_DEPTH);

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HOLD,
        TX_STROBE,
        TX_WAIT
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ACK,
        RX_WAIT
    } rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;

    logic [7:0]       fifo_mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic [1:0] ctrl;
    logic       tx_lost;

    logic       hit, rd_hit, wr_hit;
    logic [1:0] offset;
    logic       rd_data, rd_status, wr_data, wr_ctrl;
    logic       rx_not_empty, rx_full, tx_idle, irq_pending;
    logic       fifo_push, fifo_pop;
    logic       tx_load, tx_drop;
    logic [7:0] status_value;
    logic [7:0] read_value;

    // Register window decode; anything outside the window is invisible to this block
    always_comb begin
        hit       = cpuAccess && (address[15:2] == BASE_ADDR[15:2]);
        offset    = address[1:0];
        rd_hit    = hit && readNotWrite;
        wr_hit    = hit && !readNotWrite;
        rd_data   = rd_hit && (offset == OFF_DATA);
        rd_status = rd_hit && (offset == OFF_STATUS);
        wr_data   = wr_hit && (offset == OFF_DATA);
        wr_ctrl   = wr_hit && (offset == OFF_CTRL);
    end

    // Status flags and the combinational interrupt term
    always_comb begin
        rx_not_empty = (count != '0);
        rx_full      = (count == FULL_CNT);
        tx_idle      = (tx_state == TX_IDLE);
        irq_pending  = (ctrl[0] && rx_not_empty) || (ctrl[1] && tx_idle);
        status_value = {3'b000, irq_pending, tx_lost, tx_idle, rx_full, rx_not_empty};
        fifo_pop     = rd_data && rx_not_empty;
        tx_drop      = wr_data && !tx_idle;
    end

    // TX state register, registered load strobe and the held transmit byte
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            txclk    <= 1'b0;
            txdata   <= 8'h00;
        end else begin
            tx_state <= tx_next;
            txclk    <= (tx_next == TX_STROBE);
            if (tx_load) begin
                txdata <= dataBusIn;
            end
        end
    end

    // TX next state: hold the byte until the transmitter is ready, strobe once, then wait for it to go busy
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (wr_data) begin
                    tx_next = TX_HOLD;
                    tx_load = 1'b1;
                end
            end
            TX_HOLD: begin
                if (txready) begin
                    tx_next = TX_STROBE;
                end
            end
            TX_STROBE: begin
                tx_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (!txready) begin
                    tx_next = TX_IDLE;
                end
            end
            default: begin
                tx_next = TX_IDLE;
            end
        endcase
    end

    // RX state register and registered acknowledge strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rxclk    <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rxclk    <= (rx_next == RX_ACK);
        end
    end

    // RX next state: capture only when there is room, so a full FIFO back-pressures the receiver
    always_comb begin
        rx_next   = rx_state;
        fifo_push = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rxready && !rx_full) begin
                    fifo_push = 1'b1;
                    rx_next   = RX_ACK;
                end
            end
            RX_ACK: begin
                rx_next = RX_WAIT;
            end
            RX_WAIT: begin
                if (!rxready) begin
                    rx_next = RX_IDLE;
                end
            end
            default: begin
                rx_next = RX_IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= rxdata;
        end
    end

    // FIFO pointers and occupancy; push and pop on the same edge leave the count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Read data selection; reserved offset and empty DATA reads return zero
    always_comb begin
        read_value = 8'h00;
        case (offset)
            OFF_DATA: begin
                if (rx_not_empty) begin
                    read_value = fifo_mem[rd_ptr];
                end
            end
            OFF_STATUS: begin
                read_value = status_value;
            end
            OFF_CTRL: begin
                read_value = {6'b000000, ctrl};
            end
            default: begin
                read_value = 8'h00;
            end
        endcase
    end

    // CPU-visible registers: control, sticky lost flag, read data and interrupt line
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl             <= 2'b00;
            tx_lost          <= 1'b0;
            dataBusOut       <= 8'h00;
            interruptRequest <= 1'b0;
        end else begin
            interruptRequest <= irq_pending;
            if (wr_ctrl) begin
                ctrl <= dataBusIn[1:0];
            end
            if (tx_drop) begin
                tx_lost <= 1'b1;
            end else if (rd_status) begin
                tx_lost <= 1'b0;
            end
            if (rd_hit) begin
                dataBusOut <= read_value;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_responder.sv
// tb/tb_uart_bus_responder.sv - vector table, directed sequences and random run against a reference model
module tb_uart_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        cpuAccess;
    logic        readNotWrite;
    logic [7:0]  dataBusIn;
    logic [7:0]  dataBusOut;
    logic        interruptRequest;
    logic [7:0]  txdata;
    logic        txclk;
    logic        txready;
    logic [7:0]  rxdata;
    logic        rxclk;
    logic        rxready;

    int n_checks = 0;
    int n_fail   = 0;

    uart_bus_responder #(
        .BASE_ADDR(16'hC000),
        .RX_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .cpuAccess       (cpuAccess),
        .readNotWrite    (readNotWrite),
        .dataBusIn       (dataBusIn),
        .dataBusOut      (dataBusOut),
        .interruptRequest(interruptRequest),
        .txdata          (txdata),
        .txclk           (txclk),
        .txready         (txready),
        .rxdata          (rxdata),
        .rxclk           (rxclk),
        .rxready         (rxready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        acc;
        logic [15:0] addr;
        logic        rnw;
        logic [7:0]  din;
        logic        txr;
        logic [7:0]  e_dout;
        logic [7:0]  e_txdata;
        logic        e_txclk;
        logic        e_irq;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    byte unsigned mq[$];
    int           m_rx;
    int           m_tx;
    logic [7:0]   m_txd, m_dout;
    logic [1:0]   m_ctrl;
    logic         m_lost, m_irq, m_txclk, m_rxclk;

    function automatic vec_t mk(input logic acc, input logic [15:0] a, input logic rnw,
                                input logic [7:0] din, input logic txr, input logic [7:0] ed,
                                input logic [7:0] etd, input logic etc, input logic eirq);
        vec_t v;
        v.acc = acc; v.addr = a; v.rnw = rnw; v.din = din; v.txr = txr;
        v.e_dout = ed; v.e_txdata = etd; v.e_txclk = etc; v.e_irq = eirq;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        address = a; readNotWrite = 1'b1; cpuAccess = 1'b1;
        tick();
        d = dataBusOut;
        cpuAccess = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        address = a; readNotWrite = 1'b0; dataBusIn = d; cpuAccess = 1'b1;
        tick();
        cpuAccess = 1'b0;
    endtask

    // One clock edge of the behavioural model, from the current model state and bench inputs
    task automatic model_step();
        logic       hit, ne_pre, full_pre, idle_pre, pend, load;
        logic [1:0] off;
        logic [7:0] st;
        if (reset) begin
            mq.delete();
            m_rx = 0; m_tx = 0; m_txd = 8'h00; m_dout = 8'h00; m_ctrl = 2'b00;
            m_lost = 1'b0; m_irq = 1'b0; m_txclk = 1'b0; m_rxclk = 1'b0;
            return;
        end
        hit      = cpuAccess && ((address & 16'hFFFC) == 16'hC000);
        off      = address[1:0];
        ne_pre   = (mq.size() != 0);
        full_pre = (mq.size() == 4);
        idle_pre = (m_tx == 0);
        pend     = (m_ctrl[0] && ne_pre) || (m_ctrl[1] && idle_pre);
        st       = {3'b000, pend, m_lost, idle_pre, full_pre, ne_pre};
        m_irq    = pend;
        load     = 1'b0;
        if (hit && readNotWrite) begin
            case (off)
                2'd0: m_dout = ne_pre ? mq.pop_front() : 8'h00;
                2'd1: begin m_dout = st; m_lost = 1'b0; end
                2'd2: m_dout = {6'b0, m_ctrl};
                default: m_dout = 8'h00;
            endcase
        end
        if (hit && !readNotWrite) begin
            if (off == 2'd0) begin
                if (idle_pre) begin m_txd = dataBusIn; load = 1'b1; end
                else m_lost = 1'b1;
            end
            if (off == 2'd2) m_ctrl = dataBusIn[1:0];
        end
        if (load) m_tx = 1;
        else if (m_tx == 1 && txready) m_tx = 2;
        else if (m_tx == 2) m_tx = 3;
        else if (m_tx == 3 && !txready) m_tx = 0;
        if (m_rx == 0 && rxready && !full_pre) begin
            mq.push_back(rxdata);
            m_rx = 1;
        end else if (m_rx == 1) m_rx = 2;
        else if (m_rx == 2 && !rxready) m_rx = 0;
        m_txclk = (m_tx == 2);
        m_rxclk = (m_rx == 1);
    endtask

    initial begin
        logic [7:0] d;
        int         pulses;
        logic       got;

        reset = 1'b1; address = 16'h0000; cpuAccess = 1'b0; readNotWrite = 1'b1;
        dataBusIn = 8'h00; txready = 1'b0; rxdata = 8'h00; rxready = 1'b0;
        tick();
        tick();
        check("reset_dout", dataBusOut, 8'h00);
        check("reset_txdata", txdata, 8'h00);
        check("reset_strobes", {6'b0, txclk, rxclk}, 8'h00);
        check("reset_irq", {7'b0, interruptRequest}, 8'h00);
        reset = 1'b0;

        // acc, addr, rnw, din, txready, exp dout, exp txdata, exp txclk, exp irq
        vecs.push_back(mk(1'b1, 16'hC001, 1'b1, 8'h00, 1'b0, 8'h04, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC000, 1'b0, 8'h41, 1'b0, 8'h04, 8'h41, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h04, 8'h41, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 8'h04, 8'h41, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 8'h04, 8'h41, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 8'h04, 8'h41, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC000, 1'b0, 8'h55, 1'b1, 8'h04, 8'h41, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h04, 8'h41, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC001, 1'b1, 8'h00, 1'b0, 8'h0C, 8'h41, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC001, 1'b1, 8'h00, 1'b0, 8'h04, 8'h41, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC000, 1'b0, 8'h42, 1'b0, 8'h04, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC000, 1'b0, 8'h43, 1'b0, 8'h04, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC001, 1'b1, 8'h00, 1'b0, 8'h08, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC001, 1'b1, 8'h00, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 8'h00, 8'h42, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC001, 1'b1, 8'h00, 1'b0, 8'h04, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC003, 1'b0, 8'hFF, 1'b0, 8'h04, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC003, 1'b1, 8'h00, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC002, 1'b0, 8'h02, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h00, 8'h42, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 16'hC002, 1'b1, 8'h00, 1'b0, 8'h02, 8'h42, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 16'hC005, 1'b1, 8'h00, 1'b0, 8'h02, 8'h42, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 16'hC006, 1'b0, 8'h00, 1'b0, 8'h02, 8'h42, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h02, 8'h42, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 16'hC002, 1'b0, 8'h00, 1'b0, 8'h02, 8'h42, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h02, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 16'hC000, 1'b0, 8'h99, 1'b0, 8'h02, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hC001, 1'b1, 8'h00, 1'b0, 8'h04, 8'h42, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            cpuAccess = vecs[i].acc; address = vecs[i].addr; readNotWrite = vecs[i].rnw;
            dataBusIn = vecs[i].din; txready = vecs[i].txr;
            tick();
            check($sformatf("vec%0d_dout", i), dataBusOut, vecs[i].e_dout);
            check($sformatf("vec%0d_txdata", i), txdata, vecs[i].e_txdata);
            check($sformatf("vec%0d_txclk", i), {7'b0, txclk}, {7'b0, vecs[i].e_txclk});
            check($sformatf("vec%0d_rxclk", i), {7'b0, rxclk}, 8'h00);
            check($sformatf("vec%0d_irq", i), {7'b0, interruptRequest}, {7'b0, vecs[i].e_irq});
        end
        cpuAccess = 1'b0;

        // RX fill to full with TX parked in HOLD, then back-pressure and drain
        txready = 1'b0;
        cpu_write(16'hC000, 8'h60);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            rxdata = 8'h10 + 8'(i); rxready = 1'b1;
            tick();
            check($sformatf("rx_ack%0d", i), {7'b0, rxclk}, 8'h01);
            if (rxclk) pulses++;
            rxready = 1'b0;
            tick();
            check($sformatf("rx_ack%0d_single", i), {7'b0, rxclk}, 8'h00);
            tick();
        end
        rxdata = 8'h14; rxready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rxclk) pulses++;
        end
        check("rx_pulse_count", 8'(pulses), 8'd4);
        cpu_read(16'hC001, d);
        check("rx_full_status", d, 8'h03);
        cpu_read(16'hC000, d);
        check("rx_first_byte", d, 8'h10);
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            tick();
            got = rxclk;
        end
        check("rx_fifth_accepted", {7'b0, got}, 8'h01);
        rxready = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 5; i++) begin
            cpu_read(16'hC000, d);
            check($sformatf("rx_drain%0d", i), d, 8'h10 + 8'(i));
        end
        cpu_read(16'hC000, d);
        check("rx_empty_read", d, 8'h00);
        cpu_read(16'hC001, d);
        check("rx_empty_status", d, 8'h00);
        txready = 1'b1;
        tick();
        check("tx_park_strobe", {7'b0, txclk}, 8'h01);
        txready = 1'b0;
        tick();
        tick();

        // RX interrupt follows FIFO occupancy one cycle late; TX interrupt follows idle
        cpu_write(16'hC002, 8'h01);
        rxdata = 8'h77; rxready = 1'b1;
        tick();
        check("irq_push_edge", {7'b0, interruptRequest}, 8'h00);
        rxready = 1'b0;
        tick();
        check("irq_rise", {7'b0, interruptRequest}, 8'h01);
        tick();
        cpu_read(16'hC000, d);
        check("irq_pop_data", d, 8'h77);
        check("irq_pop_edge", {7'b0, interruptRequest}, 8'h01);
        tick();
        check("irq_fall", {7'b0, interruptRequest}, 8'h00);
        cpu_write(16'hC002, 8'h02);
        tick();
        check("irq_tx_idle", {7'b0, interruptRequest}, 8'h01);

        // Reset while both strobes are high
        cpu_write(16'hC000, 8'h5A);
        txready = 1'b1; rxready = 1'b1; rxdata = 8'h33;
        tick();
        check("mid_txclk_high", {7'b0, txclk}, 8'h01);
        check("mid_rxclk_high", {7'b0, rxclk}, 8'h01);
        reset = 1'b1; txready = 1'b0; rxready = 1'b0;
        tick();
        check("mid_reset_strobes", {6'b0, txclk, rxclk}, 8'h00);
        check("mid_reset_txdata", txdata, 8'h00);
        check("mid_reset_irq", {7'b0, interruptRequest}, 8'h00);
        reset = 1'b0;
        tick();
        cpu_read(16'hC001, d);
        check("mid_reset_status", d, 8'h04);
        cpu_read(16'hC000, d);
        check("mid_reset_fifo_empty", d, 8'h00);
        check("mid_reset_irq_after", {7'b0, interruptRequest}, 8'h00);

        // Randomised run against the reference model
        reset = 1'b1; cpuAccess = 1'b0; txready = 1'b0; rxready = 1'b0;
        model_step();
        tick();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset        = ($urandom_range(0, 399) == 0);
            cpuAccess    = 1'($urandom_range(0, 1));
            address      = ($urandom_range(0, 3) != 0) ? {14'h3000, 2'($urandom_range(0, 3))}
                                                       : 16'($urandom);
            readNotWrite = 1'($urandom_range(0, 1));
            dataBusIn    = 8'($urandom);
            rxdata       = 8'($urandom);
            if ($urandom_range(0, 2) == 0) txready = ~txready;
            if ($urandom_range(0, 2) == 0) rxready = ~rxready;
            model_step();
            tick();
            check("rnd_dout", dataBusOut, m_dout);
            check("rnd_txdata", txdata, m_txd);
            check("rnd_txclk", {7'b0, txclk}, {7'b0, m_txclk});
            check("rnd_rxclk", {7'b0, rxclk}, {7'b0, m_rxclk});
            check("rnd_irq", {7'b0, interruptRequest}, {7'b0, m_irq});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
